score_bcd_tracker: RTL

Parametrised score display front-end for the seven-segment path.
- Tracks the running high score against the live score.
- Converts both values to packed BCD with a shared serial double-dabble engine, one bit per clock.
- Publishes both digit vectors atomically with a done pulse.
- Replaces the per-cycle divide/modulo approach, which does not scale with width.

---
 rtl/score_bcd_tracker_pkg.sv | 26 ++
 rtl/score_bcd_tracker_bin2bcd_step.sv | 26 ++
 rtl/score_bcd_tracker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/score_bcd_tracker_pkg.sv
// score_pkg: shared types and constants for the score BCD tracker.
//   state_e    - conversion FSM states
//   BCD_BLANK  - nibble code used for a blanked display digit
//   bcd_max()  - largest value representable in a given number of BCD digits
package score_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV_CUR  = 2'd1,
    CONV_HIGH = 2'd2,
    PUBLISH   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // 10^digits - 1; digits is at most 9, so the result fits in 32 bits.
  function automatic logic [31:0] bcd_max(input int unsigned digits);
    logic [31:0] m;
    m = 32'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      m = m * 32'd10;
    end
    return m - 32'd1;
  endfunction

endpackage

// File: rtl/score_bcd_tracker_bin2bcd_step.sv
// bin2bcd_step: one combinational double-dabble step.
//   sr_i  [4*DIGITS+SCORE_W-1:0]  shift register in; BCD digits in the upper
//                                 4*DIGITS bits, remaining binary bits below
//   sr_o  [4*DIGITS+SCORE_W-1:0]  after add-3 on every digit >= 5 and a
//                                 one-bit left shift
module bin2bcd_step #(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic [4*DIGITS+SCORE_W-1:0] sr_i,
  output logic [4*DIGITS+SCORE_W-1:0] sr_o
);

  logic [4*DIGITS+SCORE_W-1:0] adj;

  always_comb begin
    adj = sr_i;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[SCORE_W+4*i +: 4] >= 4'd5) begin
        adj[SCORE_W+4*i +: 4] = adj[SCORE_W+4*i +: 4] + 4'd3;
      end
    end
    sr_o = adj << 1;
  end

endmodule

// File: rtl/score_bcd_tracker.sv
// score_bcd_tracker: high-score tracking plus serial binary-to-BCD conversion
// of the live and high scores for the seven-segment display path.
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   tick           conversion request, accepted only while idle
//   current_score  live score, unsigned
//   clr_high       synchronous clear of the high score (priority over update)
//   cur_bcd        published current-score digits, digit 0 in [3:0]
//   high_bcd       published high-score digits, same packing
//   busy           conversion in progress
//   done           one-cycle pulse, digit outputs updated this cycle
//   new_high       one-cycle pulse when the high score increases
// Build option: define SCORE_LEAD_BLANK_EN to blank leading zero digits with
// BCD_BLANK at publish time (digit 0 always shown).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for tick; snapshots both scores on acceptance
// CONV_CUR  | SCORE_W double-dabble steps on the current-score snapshot
// CONV_HIGH | SCORE_W double-dabble steps on the high-score snapshot
// PUBLISH   | both digit vectors registered together, done raised
module score_bcd_tracker
  import score_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [SCORE_W-1:0]    current_score,
  input  logic                  clr_high,
  output logic [4*DIGITS-1:0]   cur_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  new_high
);

  localparam int BCD_W = 4*DIGITS;
  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);
  localparam logic [31:0] MAX = bcd_max(DIGITS);

  // Clamp so the snapshot always fits in DIGITS digits.
  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] x);
    if (32'(x) > MAX) return SCORE_W'(MAX);
    else              return x;
  endfunction

  function automatic logic [BCD_W-1:0] fmt(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
`ifdef SCORE_LEAD_BLANK_EN
    logic lead;
    r    = v;
    lead = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) r[4*i +: 4] = BCD_BLANK;
      else                                lead = 1'b0;
    end
`else
    r = v;
`endif
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [SR_W-1:0]      sr_q, sr_d, step_out;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W-1:0]     cur_res_q, cur_res_d;
  logic [SCORE_W-1:0]   snap_high_q, snap_high_d;
  logic [BCD_W-1:0]     cur_bcd_q, cur_bcd_d;
  logic [BCD_W-1:0]     high_bcd_q, high_bcd_d;
  logic                 done_q, done_d;
  logic [SCORE_W-1:0]   high_q;
  logic                 new_high_q;

  bin2bcd_step #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_step (
    .sr_i (sr_q),
    .sr_o (step_out)
  );

  // High score tracks the live score every cycle, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      new_high_q <= 1'b0;
      if (clr_high) begin
        high_q <= '0;
      end else if (current_score > high_q) begin
        high_q     <= current_score;
        new_high_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      cur_res_q   <= '0;
      snap_high_q <= '0;
      cur_bcd_q   <= '0;
      high_bcd_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      cur_res_q   <= cur_res_d;
      snap_high_q <= snap_high_d;
      cur_bcd_q   <= cur_bcd_d;
      high_bcd_q  <= high_bcd_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    cur_res_d   = cur_res_q;
    snap_high_d = snap_high_q;
    cur_bcd_d   = cur_bcd_q;
    high_bcd_d  = high_bcd_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          sr_d        = {{BCD_W{1'b0}}, sat(current_score)};
          snap_high_d = sat(high_q);
          cnt_d       = '0;
          state_d     = CONV_CUR;
        end
      end
      CONV_CUR: begin
        sr_d  = step_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Park the finished current digits and reuse the shifter for high.
          cur_res_d = step_out[SR_W-1 -: BCD_W];
          sr_d      = {{BCD_W{1'b0}}, snap_high_q};
          cnt_d     = '0;
          state_d   = CONV_HIGH;
        end
      end
      CONV_HIGH: begin
        sr_d  = step_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        cur_bcd_d  = fmt(cur_res_q);
        high_bcd_d = fmt(sr_q[SR_W-1 -: BCD_W]);
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cur_bcd  = cur_bcd_q;
  assign high_bcd = high_bcd_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign new_high = new_high_q;

endmodule
